// File: rtl/speed_regulator_if.sv
// Command/feedback bundle between the speed regulator and its drive channel.
// The slave side is the regulator; the master side supplies target and
// encoder count and consumes the PWM command.
interface speed_regulator_if;
   logic               En;
   logic signed [15:0] Target;
   logic [31:0]        Count;
   logic               Dir;
   logic [31:0]        HiCount;
   logic [31:0]        LoCount;
   logic signed [15:0] Speed;
   logic               SampleValid;

   modport master (
      output En, Target, Count,
      input  Dir, HiCount, LoCount, Speed, SampleValid
   );

   modport slave (
      input  En, Target, Count,
      output Dir, HiCount, LoCount, Speed, SampleValid
   );
endinterface

// File: rtl/speed_regulator.sv
// Closed-loop speed regulator for one drive channel.
// Differentiates the encoder count once per sample period, runs a PI loop
// against the commanded target and produces Dir/HiCount/LoCount PWM command.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for the sample tick (first tick only primes)
//   S_DELTA | measure count delta, saturate into Speed
//   S_ERR   | err = Target - Speed
//   S_PI    | integrator update, PI output, drive command registered
//   S_OUT   | SampleValid high for this single cycle
module speed_regulator #(
   parameter int SAMPLE_CYCLES = 100000,
   parameter int PWM_PERIOD    = 1000,
   parameter int KP            = 4,
   parameter int KI            = 1,
   parameter int GAIN_SHIFT    = 2,
   parameter int INT_LIMIT     = 4000
) (
   input logic              clk,
   input logic              rst,
   speed_regulator_if.slave bus
);

   localparam int TW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
   localparam int AW = 48;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DELTA = 3'd1;
   localparam logic [2:0] S_ERR   = 3'd2;
   localparam logic [2:0] S_PI    = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;

   localparam logic [TW-1:0]        C_TERM  = TW'(SAMPLE_CYCLES - 1);
   localparam logic signed [AW-1:0] C_KP    = AW'(KP);
   localparam logic signed [AW-1:0] C_KI    = AW'(KI);
   localparam logic signed [AW-1:0] C_LIM   = AW'(INT_LIMIT);
   localparam logic signed [AW-1:0] C_PWM   = AW'(PWM_PERIOD);
   localparam logic [31:0]          C_PWM32 = 32'(PWM_PERIOD);

   logic [TW-1:0]        r_timer;
   logic [31:0]          r_prev;
   logic                 r_primed;
   logic [2:0]           r_state;
   logic signed [15:0]   r_speed;
   logic signed [16:0]   r_err;
   logic signed [AW-1:0] r_integ;
   logic                 r_dir;
   logic [31:0]          r_hi;
   logic [31:0]          r_lo;
   logic                 r_valid;

   logic                 w_tick;
   logic signed [31:0]   w_delta;
   logic signed [15:0]   w_speed_sat;
   logic signed [16:0]   w_err_now;
   logic signed [AW-1:0] w_err_x;
   logic signed [AW-1:0] w_isum;
   logic signed [AW-1:0] w_integ_new;
   logic signed [AW-1:0] w_sum;
   logic signed [AW-1:0] w_shift;
   logic signed [AW-1:0] w_u;
   logic                 w_neg;
   logic [31:0]          w_mag;

   assign w_tick = (r_timer == C_TERM);

   // Modular 32-bit difference handles encoder wrap; then clip to 16 bits.
   assign w_delta     = bus.Count - r_prev;
   assign w_speed_sat = (w_delta > 32'sd32767)  ? 16'sh7FFF :
                        (w_delta < -32'sd32768) ? 16'sh8000 :
                        w_delta[15:0];

   assign w_err_now = {bus.Target[15], bus.Target} - {r_speed[15], r_speed};
   assign w_err_x   = {{(AW-17){r_err[16]}}, r_err};

   assign w_isum      = r_integ + w_err_x * C_KI;
   assign w_integ_new = (w_isum > C_LIM)  ? C_LIM :
                        (w_isum < -C_LIM) ? -C_LIM : w_isum;

   // Arithmetic shift floors toward minus infinity, then clip to full scale.
   assign w_sum   = w_err_x * C_KP + w_integ_new;
   assign w_shift = w_sum >>> GAIN_SHIFT;
   assign w_u     = (w_shift > C_PWM)  ? C_PWM :
                    (w_shift < -C_PWM) ? -C_PWM : w_shift;
   assign w_neg   = (w_u < 0);
   assign w_mag   = w_neg ? 32'(-w_u) : 32'(w_u);

   // Free-running sample timer, independent of the enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_timer <= '0;
      end else if (w_tick) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + TW'(1);
      end
   end

   // Measurement / PI pipeline; a low enable overrides drive and integrator.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev   <= '0;
         r_primed <= 1'b0;
         r_state  <= S_IDLE;
         r_speed  <= '0;
         r_err    <= '0;
         r_integ  <= '0;
         r_dir    <= 1'b1;
         r_hi     <= '0;
         r_lo     <= C_PWM32;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_tick) begin
                  if (r_primed) begin
                     r_state <= S_DELTA;
                  end else begin
                     r_prev   <= bus.Count;
                     r_primed <= 1'b1;
                  end
               end
            end
            S_DELTA: begin
               r_prev  <= bus.Count;
               r_speed <= w_speed_sat;
               r_state <= bus.En ? S_ERR : S_IDLE;
            end
            S_ERR: begin
               r_err   <= w_err_now;
               r_state <= S_PI;
            end
            S_PI: begin
               r_integ <= w_integ_new;
               r_dir   <= ~w_neg;
               r_hi    <= w_mag;
               r_lo    <= C_PWM32 - w_mag;
               r_valid <= 1'b1;
               r_state <= S_OUT;
            end
            S_OUT: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         if (!bus.En) begin
            r_integ <= '0;
            r_dir   <= 1'b1;
            r_hi    <= '0;
            r_lo    <= C_PWM32;
            r_valid <= 1'b0;
            if ((r_state == S_ERR) || (r_state == S_PI) || (r_state == S_OUT)) begin
               r_state <= S_IDLE;
            end
         end
      end
   end

   assign bus.Dir         = r_dir;
   assign bus.HiCount     = r_hi;
   assign bus.LoCount     = r_lo;
   assign bus.Speed       = r_speed;
   assign bus.SampleValid = r_valid;

endmodule

// File: tb/tb_speed_regulator.sv
// Bench for speed_regulator: table of per-sample vectors pushed through a
// scoreboard queue, plus hand sequences for enable drop and async reset.
module tb_speed_regulator;

   localparam int SC = 100;

   typedef struct {
      bit          clr;
      int          tgt;
      logic [31:0] cnt;
      int          speed;
      bit          dir;
      int          hi;
      int          lo;
   } vec_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   vec_t vecs[14];
   vec_t sb[$];

   speed_regulator_if bus ();

   speed_regulator #(
      .SAMPLE_CYCLES(SC),
      .PWM_PERIOD   (1000),
      .KP           (4),
      .KI           (1),
      .GAIN_SHIFT   (2),
      .INT_LIMIT    (4000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Wait for a SampleValid pulse; 'at' is the cycle stamp or -1 on timeout.
   task automatic wait_pulse(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         if (bus.SampleValid) begin
            at = cyc;
            break;
         end
      end
   endtask

   // Pop the oldest expectation and compare it with the current outputs.
   task automatic score(input string tag, input int at);
      vec_t e;
      e = sb.pop_front();
      check({tag, " pulse_seen"}, (at >= 0) ? 1 : 0, 1);
      if (at >= 0) begin
         check({tag, " speed"}, bus.Speed, e.speed);
         check({tag, " dir"},   bus.Dir,   e.dir);
         check({tag, " hi"},    bus.HiCount, e.hi);
         check({tag, " lo"},    bus.LoCount, e.lo);
      end
   endtask

   initial begin
      int   at;
      int   last;
      int   c0;
      int   seen;
      vec_t e;

      //          clr tgt    cnt            speed   dir hi    lo
      vecs[0]  = '{0,  0,    32'd1234,      0,      1,  0,    1000};
      vecs[1]  = '{1,  10,   32'd1234,      0,      1,  12,   988};
      vecs[2]  = '{0,  10,   32'd1234,      0,      1,  15,   985};
      vecs[3]  = '{1,  -50,  32'd1234,      0,      0,  63,   937};
      vecs[4]  = '{1,  2000, 32'd1234,      0,      1,  1000, 0};
      vecs[5]  = '{0,  2000, 32'd1234,      0,      1,  1000, 0};
      vecs[6]  = '{0,  2000, 32'd1234,      0,      1,  1000, 0};
      vecs[7]  = '{0,  -1100,32'd1234,      0,      0,  375,  625};
      vecs[8]  = '{1,  0,    32'hFFFFFFFB,  -1239,  1,  1000, 0};
      vecs[9]  = '{1,  10,   32'h00000005,  10,     1,  0,    1000};
      vecs[10] = '{1,  0,    32'd40005,     32767,  0,  1000, 0};
      vecs[11] = '{1,  0,    32'd5,         -32768, 1,  1000, 0};
      vecs[12] = '{1,  0,    32'd5,         0,      1,  0,    1000};
      vecs[13] = '{1,  10,   32'd5,         0,      1,  12,   988};

      rst        = 1'b1;
      bus.En     = 1'b1;
      bus.Target = 16'sd0;
      bus.Count  = 32'd1234;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset dir",   bus.Dir, 1);
      check("reset hi",    bus.HiCount, 0);
      check("reset lo",    bus.LoCount, 1000);
      check("reset speed", bus.Speed, 0);
      check("reset valid", bus.SampleValid, 0);

      @(negedge clk);
      rst = 1'b1;
      c0  = cyc;
      last = c0;

      // Table: each row is one control update.
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].clr) begin
            bus.En = 1'b0;
            @(posedge clk);
            #1;
            bus.En = 1'b1;
         end
         bus.Target = 16'(vecs[i].tgt);
         bus.Count  = vecs[i].cnt;
         sb.push_back(vecs[i]);
         wait_pulse((i == 0) ? 260 : 160, at);
         score($sformatf("row%0d", i), at);
         if (at >= 0) begin
            if (i == 0) check("row0 first_pulse_delay", at - c0, 2*SC + 3);
            else        check($sformatf("row%0d interval", i), at - last, SC);
            last = at;
         end
      end

      // En dropped while the pipeline sits in ERR.
      seen = 0;
      for (int k = 0; k < SC - 2; k++) begin
         @(posedge clk);
         #1;
         if (bus.SampleValid) seen = 1;
      end
      bus.En = 1'b0;
      @(posedge clk);
      #1;
      check("endrop dir", bus.Dir, 1);
      check("endrop hi",  bus.HiCount, 0);
      check("endrop lo",  bus.LoCount, 1000);
      bus.Count = 32'd12;
      for (int k = 0; k < 105; k++) begin
         @(posedge clk);
         #1;
         if (bus.SampleValid) seen = 1;
      end
      check("endrop no_pulse", seen, 0);
      check("endrop speed_while_off", bus.Speed, 7);
      bus.En = 1'b1;
      e = '{0, 10, 32'd12, 0, 1, 12, 988};
      sb.push_back(e);
      wait_pulse(160, at);
      score("reenable", at);
      if (at >= 0) check("reenable interval", at - last, 3*SC);

      // Asynchronous reset in the middle of a sample period.
      repeat (50) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("areset hi",    bus.HiCount, 0);
      check("areset lo",    bus.LoCount, 1000);
      check("areset dir",   bus.Dir, 1);
      check("areset valid", bus.SampleValid, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      c0  = cyc;
      e = '{0, 10, 32'd12, 0, 1, 12, 988};
      sb.push_back(e);
      wait_pulse(260, at);
      score("postreset", at);
      if (at >= 0) check("postreset first_pulse_delay", at - c0, 2*SC + 3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/speed_regulator.md
Name: speed_regulator

Overview:
Closed-loop speed regulator for one drive channel. It samples the 32-bit quadrature position count from the motor controller at a fixed period and differentiates it into a signed speed. A PI loop compares that speed against a commanded target. The result drives the motor controller's Dir / HiCount / LoCount PWM command inputs, closing the loop between encoder feedback and H-bridge drive.

Parameters:
SAMPLE_CYCLES, 100000, clk cycles per speed sample (>= 8)
PWM_PERIOD, 1000, HiCount+LoCount sum; full-scale drive magnitude
KP, 4, proportional gain (unsigned integer)
KI, 1, integral gain (unsigned integer)
GAIN_SHIFT, 2, arithmetic right shift applied to P+I sum
INT_LIMIT, 4000, integrator clamp magnitude

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
En  in  1  loop enable; low = drive off, integrator cleared
Target  in  16  signed commanded speed, counts per sample
Count  in  32  encoder position from motor controller, free-running, wraps
Dir  out  1  drive direction to motor controller
HiCount  out  32  PWM high-phase length
LoCount  out  32  PWM low-phase length
Speed  out  16  signed measured speed, counts per sample
SampleValid  out  1  one-cycle pulse when Dir/HiCount/LoCount update

Behaviour:
- Reset (rst=0, async) values: Dir=1, HiCount=0, LoCount=PWM_PERIOD, Speed=0, SampleValid=0. Internal state: timer=0, prevCount=0, integ=0, primed=0, FSM=IDLE.
- Sample timer counts 0..SAMPLE_CYCLES-1 and wraps. Tick = timer at terminal value. The timer runs regardless of En.
- Tick at cycle T with primed=0: latch prevCount=Count, set primed=1. No Speed update and no SampleValid.
- Tick with primed=1, FSM IDLE -> DELTA -> ERR -> PI -> OUT -> IDLE:
  - T+1 (DELTA): delta=Count-prevCount, 32-bit modular subtraction, so wrap-around is correct. prevCount<=Count. Speed<=delta saturated to [-32768, 32767].
  - T+2 (ERR): err=Target-Speed, 17-bit signed. Target is sampled here.
  - T+3 (PI): integ<=clamp(integ+err*KI, +/-INT_LIMIT). u=(err*KP+integ_new)>>>GAIN_SHIFT, arithmetic shift (floor). u is saturated to +/-PWM_PERIOD.
  - T+4 (OUT): Dir<=(u>=0). HiCount<=|u|. LoCount<=PWM_PERIOD-|u|. SampleValid=1 this cycle only.
- |u|=0 gives HiCount=0 (drive off). |u|=PWM_PERIOD gives LoCount=0 (full drive). HiCount+LoCount always equals PWM_PERIOD.
- Internal arithmetic is wide enough (>=40 bits) that no intermediate overflows before the saturation steps.
- En=0:
  - Speed measurement continues and updates Speed at T+1.
  - integ held at 0; the pipeline does not enter ERR.
  - Outputs forced to reset drive values (Dir=1, HiCount=0, LoCount=PWM_PERIOD) on the next clock.
  - SampleValid stays 0.
- En falling mid-pipeline (ERR/PI/OUT): abort to IDLE, clear integ, force drive-off next clock, no SampleValid.
- En rising: first control update occurs at the next tick. The integrator starts from 0.
- A tick that lands while the FSM is not IDLE cannot occur, because SAMPLE_CYCLES >= 8.
- Async reset mid-pipeline: all state returns to reset values immediately. primed=0, so the first post-reset tick only re-primes.

Test Plan:
(Bench params: SAMPLE_CYCLES=100, PWM_PERIOD=1000, KP=4, KI=1, GAIN_SHIFT=2, INT_LIMIT=4000.)
- Reset release, En=1, Target=0, Count=1234 constant -> first tick gives no SampleValid. Second tick: SampleValid at T+4 with Speed=0, HiCount=0, LoCount=1000, Dir=1, and the pulse recurs every 100 cycles.
- Target=+10, Count static -> 1st update HiCount=12, LoCount=988, Dir=1 (integ=10, u=50>>>2). 2nd update HiCount=15, LoCount=985 (integ=20).
- Target=-50, Count static -> u=-250>>>2=-63, so Dir=0, HiCount=63, LoCount=937.
- Target=+2000, Count static -> 1st update HiCount=1000, LoCount=0. integ=2000 then 4000, and stays clamped at 4000 on the 3rd and later updates.
- Wrap and saturation: Count=32'hFFFFFFFB at tick N, then 32'h00000005 at tick N+1 -> Speed=+10. A Count step of +40000 between ticks -> Speed=32767.
- Drop En at T+2 with Target=+10 -> no SampleValid; HiCount=0, LoCount=1000 one clock later; integ=0. Re-assert En -> next update matches the first-update values (HiCount=12). Pulse rst low mid-sample -> outputs reset asynchronously; the next tick only primes.
